// File: rtl/efuse_ip_model.sv
// Cycle-level behavioural model of an OTP eFuse macro: streamed load into a shadow register.
// The program path (OR-write after a fixed delay) is built only when EFUSE_MODEL_PGM_EN is defined.
module efuse_ip_model #(
  parameter int unsigned DATA_NUM = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned LOAD_CYC = 4,
  parameter int unsigned PGM_CYC  = 16,
  parameter int unsigned AW       = $clog2(DATA_NUM)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_efuse_load_req,
  input  logic                   i_efuse_pgm_req,
  input  logic [AW-1:0]          i_efuse_pgm_addr,
  input  logic [DW-1:0]          i_efuse_pgm_data,
  output logic                   o_efuse_busy,
  output logic                   o_efuse_load_done,
  output logic                   o_efuse_op_finish,
  output logic                   o_efuse_reg_update,
  output logic                   o_efuse_pgm_err,
  output logic [DATA_NUM*DW-1:0] o_efuse_reg_data
);

  localparam int unsigned CycMax = (LOAD_CYC > PGM_CYC) ? LOAD_CYC : PGM_CYC;
  localparam int unsigned CW     = (CycMax > 1) ? $clog2(CycMax) : 1;
  localparam int unsigned WW     = $clog2(DATA_NUM);
  localparam logic [CW-1:0] LoadLast = CW'(LOAD_CYC - 1);
  localparam logic [WW-1:0] WordLast = WW'(DATA_NUM - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StPgm, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          ccnt_q, ccnt_d;
  logic [WW-1:0]          wcnt_q, wcnt_d;
  logic                   is_load_q;
  logic                   load_start, shadow_we;
  logic [DW-1:0]          fuse_rd;
  logic                   busy_q, op_finish_q, reg_update_q, load_done_q;
  logic [DATA_NUM*DW-1:0] reg_data_q;

`ifdef EFUSE_MODEL_PGM_EN
  localparam logic [CW-1:0] PgmLast = CW'(PGM_CYC - 1);

  logic          pgm_start, fuse_we, pgm_oor, pgm_err_q;
  logic [AW-1:0] pgm_addr_q;
  logic [DW-1:0] pgm_data_q;
  logic [DW-1:0] fuse_q [DATA_NUM];

  assign pgm_oor = (32'(pgm_addr_q) >= DATA_NUM);
  assign fuse_rd = fuse_q[wcnt_q];
`else
  logic unused_pgm;
  assign unused_pgm = ^{i_efuse_pgm_req, i_efuse_pgm_addr, i_efuse_pgm_data};
  // Fixed array: only the last word (end-of-list marker) is blown.
  assign fuse_rd = {DW{wcnt_q == WordLast}};
`endif

  always_comb begin
    state_d    = state_q;
    ccnt_d     = ccnt_q;
    wcnt_d     = wcnt_q;
    load_start = 1'b0;
    shadow_we  = 1'b0;
`ifdef EFUSE_MODEL_PGM_EN
    pgm_start  = 1'b0;
    fuse_we    = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (i_efuse_load_req) begin
          state_d    = StLoad;
          ccnt_d     = '0;
          wcnt_d     = '0;
          load_start = 1'b1;
        end
`ifdef EFUSE_MODEL_PGM_EN
        else if (i_efuse_pgm_req) begin
          state_d   = StPgm;
          ccnt_d    = '0;
          pgm_start = 1'b1;
        end
`endif
      end
      StLoad: begin
        if (ccnt_q == LoadLast) begin
          ccnt_d    = '0;
          shadow_we = 1'b1;
          if (wcnt_q == WordLast) state_d = StDone;
          else                    wcnt_d  = wcnt_q + 1'b1;
        end else begin
          ccnt_d = ccnt_q + 1'b1;
        end
      end
`ifdef EFUSE_MODEL_PGM_EN
      StPgm: begin
        if (ccnt_q == PgmLast) begin
          fuse_we = !pgm_oor;
          state_d = StDone;
        end else begin
          ccnt_d = ccnt_q + 1'b1;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs are registered, so they trail the state by one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      ccnt_q       <= '0;
      wcnt_q       <= '0;
      is_load_q    <= 1'b0;
      busy_q       <= 1'b0;
      op_finish_q  <= 1'b0;
      reg_update_q <= 1'b0;
      load_done_q  <= 1'b0;
      reg_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      ccnt_q       <= ccnt_d;
      wcnt_q       <= wcnt_d;
      if (load_start) is_load_q <= 1'b1;
`ifdef EFUSE_MODEL_PGM_EN
      else if (pgm_start) is_load_q <= 1'b0;
`endif
      busy_q       <= (state_q != StIdle);
      op_finish_q  <= (state_q == StDone);
      reg_update_q <= (state_q == StDone) && is_load_q;
      if (load_start)        load_done_q <= 1'b0;
      else if (reg_update_q) load_done_q <= 1'b1;
      if (shadow_we) reg_data_q[32'(wcnt_q)*DW +: DW] <= fuse_rd;
    end
  end

`ifdef EFUSE_MODEL_PGM_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pgm_addr_q <= '0;
      pgm_data_q <= '0;
      pgm_err_q  <= 1'b0;
      for (int unsigned i = 0; i < DATA_NUM; i++) fuse_q[i] <= {DW{i == DATA_NUM - 1}};
    end else begin
      if (pgm_start) begin
        pgm_addr_q <= i_efuse_pgm_addr;
        pgm_data_q <= i_efuse_pgm_data;
      end
      // OTP: bits can only be blown, never cleared.
      if (fuse_we) fuse_q[pgm_addr_q] <= fuse_q[pgm_addr_q] | pgm_data_q;
      pgm_err_q <= (state_q == StDone) && !is_load_q && pgm_oor;
    end
  end

  assign o_efuse_pgm_err = pgm_err_q;
`else
  assign o_efuse_pgm_err = 1'b0;
`endif

  assign o_efuse_busy       = busy_q;
  assign o_efuse_load_done  = load_done_q;
  assign o_efuse_op_finish  = op_finish_q;
  assign o_efuse_reg_update = reg_update_q;
  assign o_efuse_reg_data   = reg_data_q;

endmodule

// File: doc/efuse_ip_model.md
# efuse_ip_model

Parametrised cycle-level behavioural model of an eFuse macro for block- and chip-level simulation. It holds a DATA_NUM x DW one-time-programmable array. On a load request it streams the array word by word into a shadow output register. On a program request it OR-writes one word after a fixed program delay. It sits in place of the eFuse hard macro, in front of the eFuse controller, and gives realistic load and program latency, busy and finish handshakes, and OTP (0->1 only) semantics.

## Interface
- DATA_NUM, 8, number of fuse words; >= 2
- DW, 8, bits per word
- LOAD_CYC, 4, cycles to read one word during load; >= 1
- PGM_CYC, 16, cycles to burn one word; >= 1
- AW, $clog2(DATA_NUM), program address width (derived)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset: asynchronous, active-low (i_rst_n); clock i_clk
- i_efuse_load_req  in  1  load request, level, sampled only in IDLE
- i_efuse_pgm_req  in  1  program request, level, sampled only in IDLE
- i_efuse_pgm_addr  in  AW  word address to program
- i_efuse_pgm_data  in  DW  bits to burn (1 = blow)
- o_efuse_busy  out  1  operation in progress
- o_efuse_load_done  out  1  sticky: load completed since last load start
- o_efuse_op_finish  out  1  1-cycle pulse at end of any operation
- o_efuse_reg_update  out  1  1-cycle pulse at end of a load only
- o_efuse_pgm_err  out  1  1-cycle pulse with op_finish when a program address is out of range
- o_efuse_reg_data  out  DATA_NUM*DW  shadow register, word i at [i*DW +: DW]

## Operation
- Fuse array: reset to word DATA_NUM-1 = all ones (end-of-list marker), all other words = 0. The array lives in the model and is re-initialised only by reset.
- FSM states: IDLE, LOAD, PGM, DONE.
- IDLE -> LOAD when load_req=1. IDLE -> PGM when pgm_req=1 and load_req=0. If both are high, load wins and pgm_req is ignored.
- Entering LOAD: clear load_done, clear word counter wcnt and cycle counter ccnt. Data shadow is not cleared.
- LOAD: ccnt counts 0..LOAD_CYC-1. When ccnt = LOAD_CYC-1, shadow word wcnt <= array[wcnt], ccnt <= 0, wcnt++. After word DATA_NUM-1 is written, go to DONE.
- PGM: addr and data are captured on entry. ccnt counts 0..PGM_CYC-1. At PGM_CYC-1, array[addr] <= array[addr] | data, then go to DONE. Out-of-range addr (>= DATA_NUM): the array is untouched and an error is flagged at DONE.
- DONE: assert for one cycle op_finish=1. reg_update=1 and load_done<=1 if the operation was a load. pgm_err=1 if it was a flagged program. Then go to IDLE.
- Program never updates the shadow. A new load is required to observe programmed bits.
- Requests arriving outside IDLE are ignored (not queued). A level held high restarts the operation on the cycle after DONE.
- busy = 1 in LOAD, PGM and DONE.

## Timing
- Reset values: busy 0, load_done 0, op_finish 0, reg_update 0, pgm_err 0, reg_data all 0, state IDLE.
- The request is sampled at edge E0. busy is high from E0+1.
- Load: word k updates at edge E0 + (k+1)*LOAD_CYC. The finish/update pulse is high during the cycle after edge E0 + DATA_NUM*LOAD_CYC + 1. load_done rises at the same edge that pulse ends.
- Program: array write at edge E0 + PGM_CYC. The finish pulse is high in the following cycle.
- Reset mid-operation: immediate return to reset values, including the fuse array. A partial program has no effect.
- Counters are sized for max(LOAD_CYC, PGM_CYC) and DATA_NUM. There is no wrap beyond the terminal count.

## Configuration
- EFUSE_MODEL_PGM_EN defined: program path as described.
- Not defined: the program path is removed.
  - pgm_req is ignored and the FSM never enters PGM.
  - The array is constant at its reset contents.
  - pgm_err is tied to 0.
  - The ports remain present.

## Test plan
- Reset load, defaults (DATA_NUM=8, DW=8, LOAD_CYC=4): pulse load_req -> reg_data = 64'hFF00_0000_0000_0000; op_finish and reg_update high exactly once, 34 cycles after the sampling edge; load_done stays 1.
- Program then reload (macro on, PGM_CYC=16): pgm addr 2 data 8'hA5 -> single op_finish, reg_data unchanged. Then pgm addr 2 data 8'h0F, then load -> word 2 = 8'hAF (OR semantics, no 1->0).
- Simultaneous load_req and pgm_req in IDLE -> only the load runs. The array is unchanged, verified by a subsequent load.
- Out-of-range program (DATA_NUM=6, addr 7) -> pgm_err and op_finish pulse together; array unchanged.
- Reset asserted mid-LOAD at word 3 -> all outputs at reset values immediately. A fresh load then completes normally.
- Macro off: pgm_req held high 100 cycles -> busy stays 0, no op_finish; load returns default contents.
